// File: rtl/wb2axi_burst.sv
// Wishbone B3 slave to AXI4 master bridge: single-beat writes, INCR/WRAP read bursts with prefetch FIFO.
// Optional macro WB2AXI_BURST_ERR_EN maps SLVERR/DECERR responses onto wb_err_o per beat.
module wb2axi_burst #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int AXI_ID_WIDTH = 4,
    parameter int MAX_BURST    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
    input  logic [2:0]                wb_cti_i,
    input  logic [1:0]                wb_bte_i,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic                      wb_rty_o,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SIZE   = $clog2(STRB_W);
    localparam int IW     = $clog2(MAX_BURST);
    localparam int PW     = IW + 1;
    localparam int CW     = 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_RDRAIN
    } state_t;

    // INCR length: capped by MAX_BURST and by the beats left before the next 4 KiB page.
    function automatic logic [CW-1:0] incr_len(input logic [ADDR_WIDTH-1:0] a);
        logic [CW-1:0] to_boundary;
        to_boundary = (CW'(4096) - CW'(a[11:0])) >> SIZE;
        return (to_boundary > CW'(MAX_BURST)) ? CW'(MAX_BURST) : to_boundary;
    endfunction

    state_t                  state_q, state_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [CW-1:0]           len_q, len_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    wrap_q, wrap_d;
    logic                    rlast_seen_q, rlast_seen_d;
    logic                    wack_q, wack_d;
    logic                    werr_q, werr_d;
    logic                    rerr_sticky_q, rerr_sticky_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;

    logic [DATA_WIDTH-1:0]   fifo_mem [MAX_BURST];
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    r_hs;
    logic                    push;
    logic                    pop;
    logic                    beat_req;
    logic                    head_err;
    logic                    rd_ack;
    logic                    rd_err;
    logic [CW-1:0]           new_len;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    unused_inputs;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[IW] != rd_ptr_q[IW]) &&
                        (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);

    assign m_axi_rready = ((state_q == S_RDATA) && !fifo_full) || (state_q == S_RDRAIN);
    assign r_hs         = m_axi_rvalid && m_axi_rready;
    assign push         = r_hs && (state_q == S_RDATA);

    // A WB read beat is served straight from the FIFO head in the same cycle.
    assign beat_req = (state_q == S_RDATA) && wb_cyc_i && wb_stb_i &&
                      !fifo_empty && (cnt_q != '0);
    assign pop      = beat_req;
    assign rd_ack   = beat_req && !head_err;
    assign rd_err   = beat_req && head_err;

`ifdef WB2AXI_BURST_ERR_EN
    logic fifo_err [MAX_BURST];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_err[wr_ptr_q[IW-1:0]] <= m_axi_rresp[1];
        end
    end

    assign head_err = fifo_err[rd_ptr_q[IW-1:0]];
    assign wb_err_o = rd_err || werr_q;
`else
    assign head_err = 1'b0;
    assign wb_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[IW-1:0]] <= m_axi_rdata;
        end
    end

    assign next_addr = araddr_q + (ADDR_WIDTH'(len_q) << SIZE);

    always_comb begin
        state_d       = state_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        awaddr_d      = awaddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        araddr_d      = araddr_q;
        len_d         = len_q;
        wrap_d        = wrap_q;
        wack_d        = 1'b0;
        werr_d        = 1'b0;
        new_len       = len_q;
        cnt_d         = cnt_q - CW'(pop);
        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        rlast_seen_d  = rlast_seen_q || (push && m_axi_rlast);
        rerr_sticky_d = rerr_sticky_q || (push && m_axi_rresp[1]);

        case (state_q)
            S_IDLE: begin
                // The cycle carrying a write ack must not restart on the same strobe.
                if (wb_cyc_i && wb_stb_i && !wack_q && !werr_q) begin
                    if (wb_we_i) begin
                        state_d   = S_WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = wb_adr_i;
                        wdata_d   = wb_dat_i;
                        wstrb_d   = wb_sel_i;
                    end else begin
                        if (wb_cti_i == 3'b010 && wb_bte_i != 2'b00) begin
                            wrap_d = 1'b1;
                            case (wb_bte_i)
                                2'b01:   new_len = CW'(4);
                                2'b10:   new_len = CW'(8);
                                default: new_len = CW'(16);
                            endcase
                        end else if (wb_cti_i == 3'b010) begin
                            wrap_d  = 1'b0;
                            new_len = incr_len(wb_adr_i);
                        end else begin
                            wrap_d  = 1'b0;
                            new_len = CW'(1);
                        end
                        state_d       = S_RADDR;
                        araddr_d      = wb_adr_i;
                        len_d         = new_len;
                        cnt_d         = new_len;
                        rlast_seen_d  = 1'b0;
                        rerr_sticky_d = 1'b0;
                    end
                end
            end
            S_WADDR: begin
                if (m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wready)  wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                    state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (m_axi_bvalid) begin
                    state_d = S_IDLE;
`ifdef WB2AXI_BURST_ERR_EN
                    werr_d  = m_axi_bresp[1];
                    wack_d  = !m_axi_bresp[1];
`else
                    wack_d  = 1'b1;
`endif
                end
            end
            S_RADDR: begin
                if (m_axi_arready) begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (cnt_q == '0) begin
                    if (!wb_cyc_i) state_d = S_IDLE;
                end else if (!wb_cyc_i || (pop && wb_cti_i == 3'b111 && cnt_q != CW'(1))) begin
                    // Early end: drop prefetched data and swallow the rest of the AXI burst.
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    if (rlast_seen_q || (r_hs && m_axi_rlast)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RDRAIN;
                    end
                end else if (pop && cnt_q == CW'(1)) begin
                    if (wb_cti_i == 3'b010 && !wrap_q) begin
                        new_len      = incr_len(next_addr);
                        state_d      = S_RADDR;
                        araddr_d     = next_addr;
                        len_d        = new_len;
                        cnt_d        = new_len;
                        rlast_seen_d = 1'b0;
                    end else if (wb_cti_i != 3'b010) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RDRAIN: begin
                if (m_axi_rvalid && m_axi_rlast) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            araddr_q      <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            wrap_q        <= 1'b0;
            rlast_seen_q  <= 1'b0;
            wack_q        <= 1'b0;
            werr_q        <= 1'b0;
            rerr_sticky_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            awaddr_q      <= awaddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            araddr_q      <= araddr_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            wrap_q        <= wrap_d;
            rlast_seen_q  <= rlast_seen_d;
            wack_q        <= wack_d;
            werr_q        <= werr_d;
            rerr_sticky_q <= rerr_sticky_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    assign wb_ack_o = wack_q || rd_ack;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = ((state_q == S_RDATA) && !fifo_empty) ? fifo_mem[rd_ptr_q[IW-1:0]] : '0;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == S_WRESP);

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'(len_q - CW'(1));
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = wrap_q ? 2'b10 : 2'b01;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;
    assign m_axi_arvalid = (state_q == S_RADDR);

    assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_bresp, m_axi_rresp, rerr_sticky_q};

endmodule
